// File: rtl/vip_flatten_pkg.sv
// Shared constants for the flatten / unflatten stream stages.
// Channel count, channel index width and pixel counter sizing.
package vip_flatten_pkg;

    localparam int NUM_CH = 16;
    localparam int CH_W = 4;

    function automatic int pix_w(input int width);
        return (width * width > 1) ? $clog2(width * width) : 1;
    endfunction

endpackage

// File: rtl/vip_skid_fifo2.sv
// Two-entry in-order skid FIFO; head is the oldest word.
// Absorbs the one read that is still in flight when the consumer stalls.
module vip_skid_fifo2 #(
    parameter int DWIDTH = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic [DWIDTH-1:0] din,
    input  logic              pop,
    output logic [1:0]        cnt,
    output logic [DWIDTH-1:0] head
);

    logic [DWIDTH-1:0] d0;
    logic [DWIDTH-1:0] d1;
    logic              pop_ok;

    assign pop_ok = pop && (cnt != 2'd0);
    assign head = d0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= 2'd0;
            d0 <= '0;
            d1 <= '0;
        end else begin
            unique case ({push, pop_ok})
                2'b10: begin
                    if (cnt == 2'd0) d0 <= din;
                    else d1 <= din;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    d0 <= d1;
                    cnt <= cnt - 2'd1;
                end
                2'b11: begin
                    // Count stays; slot 1 shifts forward before the new word lands.
                    if (cnt == 2'd1) begin
                        d0 <= din;
                    end else begin
                        d0 <= d1;
                        d1 <= din;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    no_overflow: assert property (
        @(posedge clock) disable iff (reset)
        !(push && !pop_ok && cnt == 2'd2)
    );

endmodule

// File: rtl/core_line_buffer_unflatten.sv
// De-interleaves a flat word stream round-robin into 16 channel FIFOs.
// Counts pixels per WIDTH x WIDTH map and pulses frame_done at its end.
module core_line_buffer_unflatten
    import vip_flatten_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int WIDTH = 28
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DWIDTH-1:0] ff_rdata,
    input  logic              ff_empty,
    output logic              ff_rdreq,
    output logic [DWIDTH-1:0] ff_wdata,
    output logic              ff_wrreq0,
    output logic              ff_wrreq1,
    output logic              ff_wrreq2,
    output logic              ff_wrreq3,
    output logic              ff_wrreq4,
    output logic              ff_wrreq5,
    output logic              ff_wrreq6,
    output logic              ff_wrreq7,
    output logic              ff_wrreq8,
    output logic              ff_wrreq9,
    output logic              ff_wrreq10,
    output logic              ff_wrreq11,
    output logic              ff_wrreq12,
    output logic              ff_wrreq13,
    output logic              ff_wrreq14,
    output logic              ff_wrreq15,
    input  logic              ff_full0,
    input  logic              ff_full1,
    input  logic              ff_full2,
    input  logic              ff_full3,
    input  logic              ff_full4,
    input  logic              ff_full5,
    input  logic              ff_full6,
    input  logic              ff_full7,
    input  logic              ff_full8,
    input  logic              ff_full9,
    input  logic              ff_full10,
    input  logic              ff_full11,
    input  logic              ff_full12,
    input  logic              ff_full13,
    input  logic              ff_full14,
    input  logic              ff_full15,
    output logic              frame_done
);

    localparam int PIX_W = pix_w(WIDTH);
    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(WIDTH * WIDTH - 1);
    localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);

    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] wrreq;
    logic [1:0]        cnt;
    logic [2:0]        occ;
    logic              pop;
    logic              rd_pending;
    logic [CH_W-1:0]   wr_ch;
    logic [PIX_W-1:0]  pix_cnt;

    assign full = {ff_full15, ff_full14, ff_full13, ff_full12,
                   ff_full11, ff_full10, ff_full9, ff_full8,
                   ff_full7, ff_full6, ff_full5, ff_full4,
                   ff_full3, ff_full2, ff_full1, ff_full0};

    // A full channel blocks the whole stream so order is never broken.
    assign pop = (cnt != 2'd0) && !full[wr_ch];

    // Occupancy after this edge; reads are issued only if a slot is free.
    assign occ = {1'b0, cnt} + {2'b00, rd_pending} - {2'b00, pop};
    assign ff_rdreq = !reset && !ff_empty && (occ < 3'd2);

    assign wrreq = pop ? ({{(NUM_CH-1){1'b0}}, 1'b1} << wr_ch) : '0;

    assign ff_wrreq0 = wrreq[0];
    assign ff_wrreq1 = wrreq[1];
    assign ff_wrreq2 = wrreq[2];
    assign ff_wrreq3 = wrreq[3];
    assign ff_wrreq4 = wrreq[4];
    assign ff_wrreq5 = wrreq[5];
    assign ff_wrreq6 = wrreq[6];
    assign ff_wrreq7 = wrreq[7];
    assign ff_wrreq8 = wrreq[8];
    assign ff_wrreq9 = wrreq[9];
    assign ff_wrreq10 = wrreq[10];
    assign ff_wrreq11 = wrreq[11];
    assign ff_wrreq12 = wrreq[12];
    assign ff_wrreq13 = wrreq[13];
    assign ff_wrreq14 = wrreq[14];
    assign ff_wrreq15 = wrreq[15];

    vip_skid_fifo2 #(
        .DWIDTH(DWIDTH)
    ) u_skid (
        .clock(clock),
        .reset(reset),
        .push(rd_pending),
        .din(ff_rdata),
        .pop(pop),
        .cnt(cnt),
        .head(ff_wdata)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_pending <= 1'b0;
            wr_ch <= '0;
            pix_cnt <= '0;
            frame_done <= 1'b0;
        end else begin
            rd_pending <= ff_rdreq;
            frame_done <= pop && (wr_ch == CH_LAST) && (pix_cnt == PIX_LAST);
            if (pop) begin
                wr_ch <= wr_ch + 1'b1;
                if (wr_ch == CH_LAST) begin
                    if (pix_cnt == PIX_LAST) pix_cnt <= '0;
                    else pix_cnt <= pix_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_core_line_buffer_unflatten.sv
// Directed bench: source FIFO model, 16 channel sinks, frame pulse log.
// DUT built with WIDTH=2 so one frame is 64 words.
module tb_core_line_buffer_unflatten;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] ff_rdata = '0;
    logic        ff_empty = 1'b1;
    logic        ff_rdreq;
    logic [31:0] ff_wdata;
    logic [15:0] wr;
    logic [15:0] full = '0;
    logic        frame_done;

    logic        rand_empty = 1'b0;
    logic        gate;
    logic [31:0] src_q[$];
    logic [31:0] ch_q[16][$];
    int          fd_q[$];
    int          wr_total = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    typedef struct {
        logic        rdreq;
        logic [15:0] wrreq;
        logic [31:0] wdata;
    } vec_t;

    vec_t vecs[35];

    always #5 clock = ~clock;

    core_line_buffer_unflatten #(
        .DWIDTH(32),
        .WIDTH(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .ff_rdata(ff_rdata),
        .ff_empty(ff_empty),
        .ff_rdreq(ff_rdreq),
        .ff_wdata(ff_wdata),
        .ff_wrreq0(wr[0]),
        .ff_wrreq1(wr[1]),
        .ff_wrreq2(wr[2]),
        .ff_wrreq3(wr[3]),
        .ff_wrreq4(wr[4]),
        .ff_wrreq5(wr[5]),
        .ff_wrreq6(wr[6]),
        .ff_wrreq7(wr[7]),
        .ff_wrreq8(wr[8]),
        .ff_wrreq9(wr[9]),
        .ff_wrreq10(wr[10]),
        .ff_wrreq11(wr[11]),
        .ff_wrreq12(wr[12]),
        .ff_wrreq13(wr[13]),
        .ff_wrreq14(wr[14]),
        .ff_wrreq15(wr[15]),
        .ff_full0(full[0]),
        .ff_full1(full[1]),
        .ff_full2(full[2]),
        .ff_full3(full[3]),
        .ff_full4(full[4]),
        .ff_full5(full[5]),
        .ff_full6(full[6]),
        .ff_full7(full[7]),
        .ff_full8(full[8]),
        .ff_full9(full[9]),
        .ff_full10(full[10]),
        .ff_full11(full[11]),
        .ff_full12(full[12]),
        .ff_full13(full[13]),
        .ff_full14(full[14]),
        .ff_full15(full[15]),
        .frame_done(frame_done)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Source FIFO: 1-cycle read latency, non-show-ahead.
    always @(posedge clock) begin
        if (ff_rdreq) ff_rdata <= (src_q.size() > 0) ? src_q.pop_front()
                                                     : 32'hBAD0BAD0;
    end

    always @(posedge clock) begin
        #1;
        gate = rand_empty ? 1'($urandom_range(0, 1)) : 1'b0;
        ff_empty = gate || (src_q.size() == 0);
    end

    // Sinks: record each write and every frame pulse.
    always @(negedge clock) begin
        if (!reset) begin
            if (frame_done) fd_q.push_back(wr_total);
            chk("onehot_wrreq", 32'($countones(wr) <= 1), 32'd1);
            for (int n = 0; n < 16; n++) begin
                if (wr[n]) begin
                    ch_q[n].push_back(ff_wdata);
                    wr_total++;
                end
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        full = '0;
        rand_empty = 1'b0;
        src_q.delete();
        for (int n = 0; n < 16; n++) ch_q[n].delete();
        fd_q.delete();
        wr_total = 0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_rdreq", 32'(ff_rdreq), 32'd0);
        chk("rst_wrreq", 32'(wr), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        @(posedge clock);
        #2;
        reset = 1'b0;
    endtask

    task automatic load(input int base, input int n);
        for (int k = 0; k < n; k++) src_q.push_back(32'(base + k));
    endtask

    task automatic wait_writes(input int target, input int budget);
        int c;
        c = 0;
        while (wr_total < target && c < budget) begin
            @(posedge clock);
            c++;
        end
        chk("write_timeout", 32'(wr_total >= target), 32'd1);
    endtask

    task automatic check_channels(input int base, input int per_ch);
        for (int n = 0; n < 16; n++) begin
            chk($sformatf("ch%0d_count", n), 32'(ch_q[n].size()),
                32'(per_ch));
            for (int i = 0; i < per_ch; i++) begin
                if (i < ch_q[n].size())
                    chk($sformatf("ch%0d_word%0d", n, i), ch_q[n][i],
                        32'(base + n + 16 * i));
            end
        end
    endtask

    initial begin
        int n_rd;

        // Free-flowing stream: word k lands on channel k mod 16 at cycle k+2.
        for (int c = 0; c < 35; c++) begin
            vecs[c].rdreq = (c <= 31);
            vecs[c].wrreq = (c >= 2 && c <= 33) ? (16'd1 << ((c - 2) % 16))
                                                : 16'd0;
            vecs[c].wdata = 32'(c - 2);
        end

        do_reset();
        load(0, 32);
        @(posedge clock);
        for (int c = 0; c < 35; c++) begin
            @(negedge clock);
            chk($sformatf("t1_rdreq_c%0d", c), 32'(ff_rdreq),
                32'(vecs[c].rdreq));
            chk($sformatf("t1_wrreq_c%0d", c), 32'(wr), 32'(vecs[c].wrreq));
            if (vecs[c].wrreq != 16'd0)
                chk($sformatf("t1_wdata_c%0d", c), ff_wdata, vecs[c].wdata);
        end
        chk("t1_total", 32'(wr_total), 32'd32);
        check_channels(0, 2);

        // Channel 3 full for the first 10 cycles of a stream.
        do_reset();
        full[3] = 1'b1;
        load(100, 32);
        @(posedge clock);
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (c == 2) chk("t2_wr_ch0", 32'(wr), 32'h0001);
            if (c == 4) chk("t2_wr_ch2", 32'(wr), 32'h0004);
            if (c >= 6) begin
                chk($sformatf("t2_stall_rdreq_c%0d", c), 32'(ff_rdreq), 32'd0);
                chk($sformatf("t2_stall_wrreq_c%0d", c), 32'(wr), 32'd0);
            end
        end
        @(posedge clock);
        #2;
        full[3] = 1'b0;
        wait_writes(32, 200);
        check_channels(100, 2);

        // Two frames of 64 words each.
        do_reset();
        load(0, 128);
        wait_writes(128, 400);
        repeat (3) @(posedge clock);
        chk("t3_pulses", 32'(fd_q.size()), 32'd2);
        if (fd_q.size() > 0) chk("t3_pulse0_at", 32'(fd_q[0]), 32'd64);
        if (fd_q.size() > 1) chk("t3_pulse1_at", 32'(fd_q[1]), 32'd128);
        check_channels(0, 8);

        // Random source gaps over 320 words.
        do_reset();
        rand_empty = 1'b1;
        load(1000, 320);
        wait_writes(320, 3000);
        repeat (3) @(posedge clock);
        chk("t4_total", 32'(wr_total), 32'd320);
        chk("t4_pulses", 32'(fd_q.size()), 32'd5);
        check_channels(1000, 20);

        // Reset while stalled with skid data and a read in flight.
        do_reset();
        full[3] = 1'b1;
        load(200, 32);
        @(posedge clock);
        repeat (5) @(negedge clock);
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_rdreq_drop", 32'(ff_rdreq), 32'd0);
        chk("t5_wrreq_drop", 32'(wr), 32'd0);
        do_reset();
        load(500, 16);
        wait_writes(16, 100);
        repeat (4) @(posedge clock);
        chk("t5_total", 32'(wr_total), 32'd16);
        check_channels(500, 1);

        // Every channel full: at most two reads, no writes.
        do_reset();
        full = '1;
        load(300, 10);
        @(posedge clock);
        n_rd = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (ff_rdreq) n_rd++;
            chk($sformatf("t6_wrreq_c%0d", c), 32'(wr), 32'd0);
        end
        chk("t6_reads", 32'(n_rd), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
